// File: rtl/dmem_responder.sv
// Load/store data-memory responder: one request at a time over valid/ready, fixed wait states,
// registered response over a second valid/ready. Define DMEM_ERR_EN to flag misaligned/out-of-range accesses.
module dmem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  input  logic [3:0]            i_req_be,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t                r_state;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [3:0]            r_be;
  logic [3:0]            r_cnt;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

  logic [IDX_W-1:0]      w_idx;
  logic                  w_access;
  logic                  w_wr_en;
  logic                  w_err;

  assign w_idx    = r_addr[IDX_W+1:2];
  assign w_access = (r_state == S_BUSY) && (r_cnt == 4'd0);
  assign w_wr_en  = w_access && r_we && !w_err;

`ifdef DMEM_ERR_EN
  assign w_err = (r_addr[1:0] != 2'b00) || (r_addr[ADDR_WIDTH-1:IDX_W+2] != '0);
`else
  // Byte offset and bits above the index are don't-care: addresses wrap.
  logic w_unused;
  assign w_err    = 1'b0;
  assign w_unused = ^{r_addr[1:0], r_addr[ADDR_WIDTH-1:IDX_W+2]};
`endif

  assign o_req_ready = (r_state == S_IDLE);
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_we    <= i_req_we;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
            r_be    <= i_req_be;
            r_cnt   <= 4'(WAIT_STATES);
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err;
            r_rsp_rdata <= (r_we || w_err) ? '0 : r_mem[w_idx];
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset so it maps onto RAM; a store dropped by reset
  // never writes because the async reset has already forced the FSM out of BUSY.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: WAIT_STATES=2 instance driven from a vector table
// with a response scoreboard, plus a WAIT_STATES=0 instance for back-to-back throughput.
module tb_dmem_responder;

`ifdef DMEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;

  logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic [3:0]  a_req_be;

  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [3:0]  b_req_be;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          hold;
  } vec_t;

  rsp_t sb_q[$];
  vec_t vecs[12];

  dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_STATES(2)) u_dut_ws2 (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(a_req_valid), .o_req_ready(a_req_ready), .i_req_we(a_req_we),
    .i_req_addr(a_req_addr), .i_req_wdata(a_req_wdata), .i_req_be(a_req_be),
    .o_rsp_valid(a_rsp_valid), .i_rsp_ready(a_rsp_ready),
    .o_rsp_rdata(a_rsp_rdata), .o_rsp_err(a_rsp_err)
  );

  dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut_ws0 (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(b_req_valid), .o_req_ready(b_req_ready), .i_req_we(b_req_we),
    .i_req_addr(b_req_addr), .i_req_wdata(b_req_wdata), .i_req_be(b_req_be),
    .o_rsp_valid(b_rsp_valid), .i_rsp_ready(b_rsp_ready),
    .o_rsp_rdata(b_rsp_rdata), .o_rsp_err(b_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One request on the WAIT_STATES=2 instance; hold>0 back-pressures the response for that
  // many cycles while a stray store is pulsed on the request port.
  task automatic txn(input vec_t v, input string name);
    rsp_t exp;
    int   w;
    int   lat;
    sb_q.push_back('{rdata: v.exp_rdata, err: v.exp_err});
    @(negedge clk);
    a_rsp_ready = (v.hold == 0);
    a_req_valid = 1'b1;
    a_req_we    = v.we;
    a_req_addr  = v.addr;
    a_req_wdata = v.wdata;
    a_req_be    = v.be;
    w = 0;
    while (!a_req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({name, " req_ready"}, 32'(a_req_ready), 32'd1);
    @(negedge clk);
    a_req_valid = 1'b0;
    a_req_wdata = 32'h0;
    lat = 0;
    while (!a_rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'd3);
    if (sb_q.size() == 0) begin
      check({name, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      exp = sb_q.pop_front();
      check({name, " rdata"}, a_rsp_rdata, exp.rdata);
      check({name, " err"}, 32'(a_rsp_err), 32'(exp.err));
      for (int k = 0; k < v.hold; k++) begin
        if (k == 1) begin
          a_req_valid = 1'b1;
          a_req_we    = 1'b1;
          a_req_addr  = v.addr;
          a_req_wdata = 32'h0;
          a_req_be    = 4'hF;
        end
        if (k == 3) a_req_valid = 1'b0;
        @(negedge clk);
        check($sformatf("%s hold%0d valid", name, k), 32'(a_rsp_valid), 32'd1);
        check($sformatf("%s hold%0d rdata", name, k), a_rsp_rdata, exp.rdata);
        check($sformatf("%s hold%0d err", name, k), 32'(a_rsp_err), 32'(exp.err));
        check($sformatf("%s hold%0d req_ready", name, k), 32'(a_req_ready), 32'd0);
      end
    end
    a_rsp_ready = 1'b1;
    @(negedge clk);
    check({name, " rsp_valid cleared"}, 32'(a_rsp_valid), 32'd0);
    check({name, " rdata cleared"}, a_rsp_rdata, 32'd0);
    check({name, " req_ready back"}, 32'(a_req_ready), 32'd1);
  endtask

  initial begin
    int seen;
    vec_t v;

    vecs[0]  = '{1'b1, 32'h40,   32'h12345678, 4'hF, 32'h0,        1'b0, 0};
    vecs[1]  = '{1'b0, 32'h40,   32'h0,        4'h0, 32'h12345678, 1'b0, 0};
    vecs[2]  = '{1'b1, 32'h40,   32'hAABBCCDD, 4'h5, 32'h0,        1'b0, 0};
    vecs[3]  = '{1'b0, 32'h40,   32'h0,        4'h0, 32'h12BB56DD, 1'b0, 5};
    vecs[4]  = '{1'b0, 32'h40,   32'h0,        4'h0, 32'h12BB56DD, 1'b0, 0};
    vecs[5]  = '{1'b1, 32'h0,    32'hCAFEF00D, 4'hF, 32'h0,        1'b0, 0};
    vecs[6]  = '{1'b1, 32'h40,   32'hFFFFFFFF, 4'h0, 32'h0,        1'b0, 0};
    vecs[7]  = '{1'b0, 32'h40,   32'h0,        4'h0, 32'h12BB56DD, 1'b0, 0};
    vecs[8]  = '{1'b0, 32'h41,   32'h0,        4'h0,
                 ERR_EN ? 32'h0 : 32'h12BB56DD, ERR_EN, 0};
    vecs[9]  = '{1'b1, 32'h1000, 32'h55555555, 4'hF, 32'h0,        ERR_EN, 0};
    vecs[10] = '{1'b0, 32'h0,    32'h0,        4'h0,
                 ERR_EN ? 32'hCAFEF00D : 32'h55555555, 1'b0, 0};
    vecs[11] = '{1'b0, 32'h1040, 32'h0,        4'h0,
                 ERR_EN ? 32'h0 : 32'h12BB56DD, ERR_EN, 0};

    rst_n = 1'b0;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_req_be = '0;
    a_rsp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0;
    b_rsp_ready = 1'b1;
    #2;
    check("reset req_ready", 32'(a_req_ready), 32'd1);
    check("reset rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("reset rsp_rdata", a_rsp_rdata, 32'd0);
    check("reset rsp_err", 32'(a_rsp_err), 32'd0);
    check("reset ws0 req_ready", 32'(b_req_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset in BUSY must drop the store and its response.
    v = '{1'b1, 32'h10, 32'h11111111, 4'hF, 32'h0, 1'b0, 0};
    txn(v, "prefill");
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h10;
    a_req_wdata = 32'hDEADBEEF; a_req_be = 4'hF;
    @(negedge clk);
    a_req_valid = 1'b0;
    check("drop accepted", 32'(a_req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst req_ready", 32'(a_req_ready), 32'd1);
    check("midrst rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("midrst rsp_rdata", a_rsp_rdata, 32'd0);
    check("midrst rsp_err", 32'(a_rsp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (a_rsp_valid) seen++;
    end
    check("no rsp after reset", 32'(seen), 32'd0);
    v = '{1'b0, 32'h10, 32'h0, 4'h0, 32'h11111111, 1'b0, 0};
    txn(v, "load after reset");

    for (int i = 0; i < 12; i++) txn(vecs[i], $sformatf("vec%0d", i));

    // WAIT_STATES=0: held valid/ready gives an accept every third cycle and 1-cycle responses.
    @(negedge clk);
    b_req_valid = 1'b1;
    b_req_addr  = 32'h40;
    for (int s = 0; s < 9; s++) begin
      check($sformatf("ws0 s%0d req_ready", s), 32'(b_req_ready), 32'((s % 3) == 0));
      check($sformatf("ws0 s%0d rsp_valid", s), 32'(b_rsp_valid), 32'((s % 3) == 2));
      check($sformatf("ws0 s%0d rsp_err", s), 32'(b_rsp_err), 32'd0);
      @(negedge clk);
    end
    b_req_valid = 1'b0;
    repeat (3) @(negedge clk);

    check("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
